weight_bram_ctrl: RTL

WEIGHT_BRAM_CTRL -- requirements
Module: weight_bram_ctrl

---
 rtl/ann_pkg.sv | 16 +
 rtl/weight_bram_ctrl.sv | 128 ++++++++++++
 2 files changed

// File: rtl/ann_pkg.sv
// Shared ANN definitions: default weight-memory geometry and the weight BRAM
// controller state encoding.
package ann_pkg;

  localparam int ANN_DEPTH = 28;
  localparam int ANN_AW    = 5;
  localparam int ANN_DW    = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } wbc_state_t;

endpackage

// File: rtl/weight_bram_ctrl.sv
// Weight BRAM controller: streams a DEPTH-word weight load into the neuron BRAM
// and replays it as a gapless DEPTH-word read pass toward the MAC.
module weight_bram_ctrl
  import ann_pkg::*;
#(
  parameter int DEPTH = ANN_DEPTH,
  parameter int AW    = ANN_AW,
  parameter int DW    = ANN_DW
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          LD_START,
  input  logic          LD_VALID,
  input  logic [DW-1:0] LD_DATA,
  output logic          LD_READY,
  input  logic          RD_START,
  output logic          W_VALID,
  output logic [DW-1:0] W_DATA,
  output logic          W_LAST,
  output logic          BUSY,
  output logic          DONE,
  output logic [AW-1:0] BRAM_ADDR,
  output logic [DW-1:0] BRAM_DI,
  output logic          BRAM_EN,
  output logic          BRAM_WE,
  input  logic [DW-1:0] BRAM_DO
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  wbc_state_t    r_state;
  logic [AW-1:0] r_wr_cnt;
  logic [AW-1:0] r_rd_cnt;
  logic          r_ld_ready;
  logic          r_busy;
  logic          r_w_valid;
  logic          r_w_last;
  logic          r_rd_done;
  logic [DW-1:0] r_w_data;

  logic          w_wr;
  logic          w_rd;
  logic          w_ld_done;

  // Writes complete in the handshake cycle, so the strobes follow LD_VALID directly.
  assign w_wr      = (r_state == ST_LOAD) && LD_VALID;
  assign w_rd      = (r_state == ST_READ);
  assign w_ld_done = w_wr && (r_wr_cnt == LAST_ADDR);

  assign BRAM_EN   = w_wr || w_rd;
  assign BRAM_WE   = w_wr;
  assign BRAM_ADDR = w_wr ? r_wr_cnt : (w_rd ? r_rd_cnt : '0);
  assign BRAM_DI   = w_wr ? LD_DATA : '0;

  assign LD_READY  = r_ld_ready;
  assign BUSY      = r_busy;
  assign W_VALID   = r_w_valid;
  assign W_DATA    = r_w_data;
  assign W_LAST    = r_w_last;
  assign DONE      = r_rd_done || w_ld_done;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= ST_IDLE;
      r_wr_cnt   <= '0;
      r_rd_cnt   <= '0;
      r_ld_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_w_valid  <= 1'b0;
      r_w_last   <= 1'b0;
      r_rd_done  <= 1'b0;
      r_w_data   <= '0;
    end else begin
      r_w_valid <= 1'b0;
      r_w_last  <= 1'b0;
      r_rd_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (LD_START) begin
            r_state    <= ST_LOAD;
            r_ld_ready <= 1'b1;
            r_busy     <= 1'b1;
            r_wr_cnt   <= '0;
          end else if (RD_START) begin
            r_state  <= ST_READ;
            r_busy   <= 1'b1;
            r_rd_cnt <= '0;
          end
        end
        ST_LOAD: begin
          if (w_wr) begin
            if (r_wr_cnt == LAST_ADDR) begin
              r_state    <= ST_IDLE;
              r_wr_cnt   <= '0;
              r_ld_ready <= 1'b0;
              r_busy     <= 1'b0;
            end else begin
              r_wr_cnt <= r_wr_cnt + 1'b1;
            end
          end
        end
        ST_READ: begin
          // BRAM_DO was read on the preceding negedge for the address issued this cycle.
          r_w_valid <= 1'b1;
          r_w_data  <= BRAM_DO;
          if (r_rd_cnt == LAST_ADDR) begin
            r_state   <= ST_DRAIN;
            r_rd_cnt  <= '0;
            r_w_last  <= 1'b1;
            r_rd_done <= 1'b1;
          end else begin
            r_rd_cnt <= r_rd_cnt + 1'b1;
          end
        end
        ST_DRAIN: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_ld_ready <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
